// File: rtl/mem_ctrl2way.sv
// mem_ctrl2way: miss handler between the 2-way cache wrapper and the banked main memory.
// Hits complete in the request cycle; misses write back a dirty victim, fill four words
// through an RD_LAT-deep read-tag pipe, then retry the access.
// Optional feature: define MEM_CTRL_ALIGN_CHECK_EN to reject odd byte addresses in IDLE.
module mem_ctrl2way #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        c_enable,
  output logic        c_comp,
  output logic        c_write,
  output logic        c_valid_in,
  output logic        c_invert_victimway,
  output logic [4:0]  c_tag_in,
  output logic [7:0]  c_index,
  output logic [2:0]  c_offset,
  output logic [15:0] c_data_in,
  input  logic [4:0]  c_tag_out,
  input  logic [15:0] c_data_out,
  input  logic        c_hit,
  input  logic        c_dirty,
  input  logic        c_valid,
  input  logic        c_err,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_wr,
  output logic        m_rd,
  input  logic [15:0] m_data_out,
  input  logic        m_stall,
  input  logic        m_err
);

  localparam int unsigned ST_W   = 4;
  localparam int unsigned ENT_W  = 3;              // {valid, word[1:0]}
  localparam int unsigned PIPE_W = ENT_W * RD_LAT;

  // Low two bits of WB/FILL states carry the word number.
  localparam logic [ST_W-1:0] S_IDLE  = 4'b0000;
  localparam logic [ST_W-1:0] S_FWAIT = 4'b0001;
  localparam logic [ST_W-1:0] S_RETRY = 4'b0010;
  localparam logic [ST_W-1:0] S_WB0   = 4'b0100;
  localparam logic [ST_W-1:0] S_WB1   = 4'b0101;
  localparam logic [ST_W-1:0] S_WB2   = 4'b0110;
  localparam logic [ST_W-1:0] S_WB3   = 4'b0111;
  localparam logic [ST_W-1:0] S_FILL0 = 4'b1000;
  localparam logic [ST_W-1:0] S_FILL1 = 4'b1001;
  localparam logic [ST_W-1:0] S_FILL2 = 4'b1010;
  localparam logic [ST_W-1:0] S_FILL3 = 4'b1011;

  logic [ST_W-1:0]   state, state_nxt;
  logic              miss_c;
  logic [4:0]        lat_tag;
  logic [7:0]        lat_index;
  logic [1:0]        lat_word;
  logic [15:0]       lat_data;
  logic              lat_wr;
  logic [PIPE_W-1:0] pipe;
  logic              req_c, hit_c, align_err_c, mem_acc_c;
  logic              pipe_out_vld;
  logic [1:0]        pipe_out_word;
  logic              addr_lsb_unused;

  assign req_c           = Rd | Wr;
  assign hit_c           = c_hit & c_valid;
  assign pipe_out_vld    = pipe[PIPE_W-1];
  assign pipe_out_word   = pipe[PIPE_W-2 -: 2];
  assign mem_acc_c       = (state[3:2] == 2'b10) & ~m_stall;
  assign addr_lsb_unused = Addr[0];

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign align_err_c = req_c & Addr[0];
`else
  assign align_err_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; also flags the cycle in which the missing request is latched.
  always_comb begin
    state_nxt = state;
    miss_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_c && !align_err_c && !hit_c) begin
          miss_c    = 1'b1;
          state_nxt = (c_valid & c_dirty) ? S_WB0 : S_FILL0;
        end
      end
      S_WB0, S_WB1, S_WB2, S_WB3, S_FILL0, S_FILL1, S_FILL2: begin
        if (!m_stall) state_nxt = state + 4'd1;
      end
      S_FILL3: begin
        if (!m_stall) state_nxt = S_FWAIT;
      end
      S_FWAIT: begin
        if (pipe_out_vld && pipe_out_word == 2'd3) state_nxt = S_RETRY;
      end
      S_RETRY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Missing request captured for writeback, fill and retry.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_tag   <= 5'd0;
      lat_index <= 8'd0;
      lat_word  <= 2'd0;
      lat_data  <= 16'd0;
      lat_wr    <= 1'b0;
    end else if (miss_c) begin
      lat_tag   <= Addr[15:11];
      lat_index <= Addr[10:3];
      lat_word  <= Addr[2:1];
      lat_data  <= DataIn;
      lat_wr    <= Wr;
    end
  end

  // Read-tag pipe: one {valid, word} entry per accepted fill read, out after RD_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= PIPE_W'({pipe, mem_acc_c, state[1:0]});
  end

  // Output decode; all outputs quiet while reset is asserted.
  always_comb begin
    DataOut            = 16'd0;
    Done               = 1'b0;
    Stall              = 1'b0;
    CacheHit           = 1'b0;
    err                = 1'b0;
    c_enable           = 1'b0;
    c_comp             = 1'b0;
    c_write            = 1'b0;
    c_valid_in         = 1'b0;
    c_invert_victimway = 1'b0;
    c_tag_in           = 5'd0;
    c_index            = 8'd0;
    c_offset           = 3'd0;
    c_data_in          = 16'd0;
    m_addr             = 16'd0;
    m_data_in          = 16'd0;
    m_wr               = 1'b0;
    m_rd               = 1'b0;
    if (!rst) begin
      Stall = (state != S_IDLE);
      err   = c_err | m_err;
      case (state)
        S_IDLE: begin
          if (req_c) begin
            if (align_err_c) begin
              Done = 1'b1;
              err  = 1'b1;
            end else begin
              c_enable  = 1'b1;
              c_comp    = 1'b1;
              c_write   = Wr;
              c_tag_in  = Addr[15:11];
              c_index   = Addr[10:3];
              c_offset  = {Addr[2:1], 1'b0};
              c_data_in = DataIn;
              if (hit_c) begin
                Done               = 1'b1;
                CacheHit           = 1'b1;
                DataOut            = c_data_out;
                c_invert_victimway = 1'b1;
              end
            end
          end
        end
        S_WB0, S_WB1, S_WB2, S_WB3: begin
          c_enable  = 1'b1;
          c_tag_in  = lat_tag;
          c_index   = lat_index;
          c_offset  = {state[1:0], 1'b0};
          m_wr      = 1'b1;
          m_addr    = {c_tag_out, lat_index, state[1:0], 1'b0};
          m_data_in = c_data_out;
        end
        S_FILL0, S_FILL1, S_FILL2, S_FILL3: begin
          m_rd   = 1'b1;
          m_addr = {lat_tag, lat_index, state[1:0], 1'b0};
        end
        S_FWAIT: ;
        S_RETRY: begin
          c_enable           = 1'b1;
          c_comp             = 1'b1;
          c_write            = lat_wr;
          c_tag_in           = lat_tag;
          c_index            = lat_index;
          c_offset           = {lat_word, 1'b0};
          c_data_in          = lat_data;
          Done               = 1'b1;
          DataOut            = c_data_out;
          c_invert_victimway = 1'b1;
        end
        default: err = 1'b1;
      endcase
      // Install a returning fill word; only word 3 validates the line so the way stays fixed.
      if (pipe_out_vld) begin
        c_enable   = 1'b1;
        c_comp     = 1'b0;
        c_write    = 1'b1;
        c_tag_in   = lat_tag;
        c_index    = lat_index;
        c_offset   = {pipe_out_word, 1'b0};
        c_data_in  = m_data_out;
        c_valid_in = (pipe_out_word == 2'd3);
      end
    end
  end

endmodule
